// File: rtl/mux_arb_n.sv
// rtl/mux_arb_n.sv - N-channel valid/ready multiplexer with direct or round-robin selection
//
// Purpose: forwards one word per cycle from one of N_CH producers into a
// registered output stage. The channel is either picked by an external
// select (mode=0) or by a round-robin arbiter among the valid channels (mode=1).
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_data    N_CH*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, one-hot or zero)
//   mode       0 = direct select, 1 = round-robin
//   sel        channel index used in direct mode
//   out_data   registered selected word
//   out_valid  out_data holds a word
//   out_ready  consumer accepts the word
//   out_ch     source channel of out_data
module mux_arb_n #(
  parameter int WIDTH = 64,
  parameter int N_CH  = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_ch
);

  logic [SEL_W-1:0] last_grant;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_found;
  logic [SEL_W-1:0] idx_s;
  int               idx;
  logic             pipe_ready;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  assign pipe_ready = !out_valid || out_ready;

  // Round-robin search starting just after the last served channel.
  // The index is wrapped by subtraction so N_CH need not be a power of 2.
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    idx      = 0;
    idx_s    = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      idx_s = SEL_W'(idx);
      if (!rr_found && in_valid[idx_s]) begin
        rr_found = 1'b1;
        rr_grant = idx_s;
      end
    end
  end

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (mode) begin
      grant       = rr_grant;
      grant_valid = rr_found;
    end else begin
      grant = sel;
      // Out-of-range selects grant nothing rather than aliasing a channel.
      if (int'(sel) < N_CH) grant_valid = in_valid[sel];
    end
  end

  assign xfer = pipe_ready && grant_valid;

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == SEL_W'(i)) begin
        in_ready[i] = reset_n && xfer;
        grant_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      last_grant <= SEL_W'(N_CH - 1);
    end else if (xfer) begin
      // A drain and a new transfer in the same cycle give a back-to-back word.
      out_valid  <= 1'b1;
      out_data   <= grant_data;
      out_ch     <= grant;
      last_grant <= grant;
    end else if (out_ready && out_valid) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb_n.sv
// tb/tb_mux_arb_n.sv - randomized and directed self-checking bench for mux_arb_n
module tb_mux_arb_n;

  localparam int W = 64;
  localparam int N = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [2:0]     sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [2:0]     out_ch;

  // Six-channel instance for the out-of-range select case.
  logic [6*W-1:0] in_data6;
  logic [5:0]     in_valid6;
  logic [5:0]     in_ready6;
  logic [2:0]     sel6;
  logic [W-1:0]   out_data6;
  logic           out_valid6;
  logic [2:0]     out_ch6;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  bit           m_ov;
  logic [W-1:0] m_od;
  int           m_oc;
  int           m_last;
  int           last_xfer;

  always #5 clk = ~clk;

  mux_arb_n #(.WIDTH(W), .N_CH(N)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
  );

  mux_arb_n #(.WIDTH(W), .N_CH(6)) dut6 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data6), .in_valid(in_valid6),
    .in_ready(in_ready6), .mode(1'b0), .sel(sel6), .out_data(out_data6),
    .out_valid(out_valid6), .out_ready(1'b1), .out_ch(out_ch6)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Grant rule: direct = sel if in range and valid; round-robin = the first
  // valid channel numbered above the last served one, else the lowest valid.
  task automatic model_grant(output int g, output bit gv);
    int q[$];
    g  = 0;
    gv = 0;
    for (int i = 0; i < N; i++) if (in_valid[i]) q.push_back(i);
    if (!mode) begin
      g  = int'(sel);
      gv = (g < N) && in_valid[g];
    end else if (q.size() > 0) begin
      gv = 1;
      g  = q[0];
      foreach (q[j]) if (q[j] > m_last) begin g = q[j]; break; end
    end
  endtask

  task automatic model_reset();
    m_ov = 0; m_od = '0; m_oc = 0; m_last = N - 1; last_xfer = -1;
  endtask

  // Inputs are applied at a falling edge before calling; one full cycle runs.
  task automatic step();
    int g;
    bit gv;
    bit pr;
    logic [N-1:0] er;
    #1;
    model_grant(g, gv);
    pr = !m_ov || out_ready;
    er = (pr && gv) ? N'(1 << g) : '0;
    check("in_ready", in_ready, er);
    @(posedge clk);
    last_xfer = -1;
    if (pr && gv) begin
      m_od = in_data[g*W +: W]; m_oc = g; m_ov = 1; m_last = g; last_xfer = g;
    end else if (out_ready && m_ov) begin
      m_ov = 0;
    end
    @(negedge clk);
    check("out_valid", out_valid, m_ov);
    check("out_data", out_data, m_od);
    check("out_ch", out_ch, m_oc);
  endtask

  task automatic set_word(input int ch, input logic [W-1:0] v);
    in_data[ch*W +: W] = v;
  endtask

  initial begin
    logic [W-1:0] w7;
    reset_n = 0; mode = 0; sel = 0; in_valid = '0; out_ready = 0; in_data = '0;
    in_valid6 = 6'h3F; sel6 = 3'd7; in_data6 = '0;
    for (int i = 0; i < N; i++) set_word(i, 64'hDEAD_BEEF_0000_0000 | 64'(i));
    model_reset();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    reset_n = 1;

    // Round-robin sweep from reset: ch0 first, then in order with no bubbles
    mode = 1; in_valid = '1; out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("rr_seq_ch", out_ch, 64'(k % N));
      check("rr_seq_valid", out_valid, 1);
    end

    // Direct select of ch5
    mode = 0; sel = 3'd5;
    #1 check("dir_in_ready", in_ready, 8'b0010_0000);
    step();
    check("dir_data", out_data, 64'hDEAD_BEEF_0000_0005);
    check("dir_ch", out_ch, 5);
    check("n6_in_ready", in_ready6, 0);
    check("n6_out_valid", out_valid6, 0);

    // Two direct transfers from ch3, then round-robin resumes at ch4
    sel = 3'd3;
    step(); step();
    mode = 1;
    step();
    check("switch_ch", out_ch, 4);

    // Sparse round-robin after last_grant=2
    mode = 0; sel = 3'd2;
    step();
    mode = 1; in_valid = 8'b1000_0100;
    step(); check("sparse_1", out_ch, 7);
    step(); check("sparse_2", out_ch, 2);
    w7 = 64'hC0FF_EE00_1234_0007;
    set_word(7, w7);
    step(); check("sparse_3", out_ch, 7);

    // Backpressure: output frozen, no input accepted
    in_valid = '1; out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_data", out_data, w7);
      check("bp_ch", out_ch, 7);
      check("bp_valid", out_valid, 1);
    end
    out_ready = 1;
    #1 check("bp_release_ready", in_ready, 8'h01);
    step();
    check("bp_release_ch", out_ch, 0);

    // Randomized traffic with producers holding valid until served
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0) sel = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (i == last_xfer || !in_valid[i]) begin
          in_valid[i] = ($urandom_range(0, 1) == 1);
          set_word(i, {$urandom, $urandom});
        end
      end
      step();
    end

    // Reset with a word in flight clears the output without a clock edge
    mode = 1; in_valid = '1; out_ready = 1;
    step();
    check("pre_rst_valid", out_valid, 1);
    #2 reset_n = 0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_ch", out_ch, 0);
    check("mid_rst_ready", in_ready, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1;
    step();
    check("post_rst_ch", out_ch, 0);
    check("post_rst_valid", out_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer with a registered output and valid/ready handshakes on every input and on the output.
- Two selection modes:
  - direct: an external select picks the channel.
  - round-robin: an internal arbiter picks among the valid channels.
- Used on the datapath wherever several 64-bit producers share one consumer, e.g. writeback/forwarding sources or memory request ports.
- Replaces the fixed 8:1 bit-select mux wherever flow control or fairness is needed.

Parameters:
- WIDTH, 64, data bits per channel.
- N_CH, 8, number of input channels (≥2, need not be a power of 2).
- SEL_W, $clog2(N_CH), width of the select and channel-id fields.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready (combinational).
- mode  input  1  0 = direct select, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode = 0.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer accepts the word.
- out_ch  output  SEL_W  source channel of the current out_data.

Behaviour:
- **Reset** (async assert, sync use after deassert):
  - out_valid=0, out_data=0, out_ch=0.
  - Internal last_grant=N_CH-1, so the first round-robin search starts at ch0.
  - in_ready=0 while reset_n=0.
- **Stage ready:** pipe_ready = !out_valid || out_ready.
- **Grant, combinational, mode 0:**
  - grant_valid = (sel < N_CH) && in_valid[sel]; grant = sel.
  - sel ≥ N_CH: no grant, all in_ready=0.
- **Grant, combinational, mode 1:**
  - Search channels last_grant+1, last_grant+2, … modulo N_CH, wrapping N_CH-1 → 0.
  - The first channel with in_valid=1 is granted; grant_valid = |in_valid.
- **in_ready[i]** = pipe_ready && grant_valid && (grant==i). At most one bit is high per cycle.
- **Input transfer** on channel i occurs when in_valid[i] && in_ready[i] at a rising edge. On that edge:
  - out_data ← in_data[i], out_ch ← i, out_valid ← 1.
  - last_grant ← i. last_grant updates on every transfer in both modes, so a switch to mode 1 continues fairly from the last served channel.
- **Otherwise**, if out_ready && out_valid: out_valid ← 0; out_data and out_ch hold their last values.
- **Latency and throughput:**
  - Latency is 1 cycle from input transfer to out_valid.
  - Throughput is one word per cycle while out_ready=1: a simultaneous output drain and input transfer produces a back-to-back word with no bubble.
- **Backpressure:**
  - While out_valid=1 and out_ready=0, out_data, out_ch and out_valid hold stable.
  - All in_ready=0 and last_grant is unchanged.
- **No-skip rule:** a channel is never granted while it drops valid. A producer may lower in_valid only after its transfer.
- **Mode or sel change:** takes effect on the grant in the same cycle it is applied. The word already in the output register is unaffected.
- **Reset mid-operation:** the in-flight output word is discarded (out_valid→0 immediately) and the arbiter pointer returns to N_CH-1.
- **Fairness:** in mode 1 with all N_CH channels continuously valid and out_ready=1, grants cycle 0,1,…,N_CH-1,0,… One grant per channel per N_CH cycles; no starvation.

Test Plan:
- **Reset check:** reset_n=0 mid-stream with out_valid=1.
  - out_valid=0, out_data=0 and out_ch=0 immediately, without waiting for a clock edge.
  - After release, mode=1 with all valid grants ch0 first.
- **Direct mode:** mode=0, sel=5, in_valid=8'hFF, ch5 data=64'hDEAD_BEEF_0000_0005, out_ready=1.
  - in_ready=8'b0010_0000.
  - Next cycle out_data=64'hDEAD_BEEF_0000_0005, out_ch=5, out_valid=1.
  - With N_CH=6 and sel=7: in_ready=0, out_valid stays 0.
- **Round-robin sweep:** mode=1, in_valid=8'hFF held, out_ready=1 for 10 cycles.
  - out_ch sequence 0,1,2,3,4,5,6,7,0,1; out_valid continuously 1 from cycle 1.
- **Sparse round-robin with wrap:** mode=1, in_valid=8'b1000_0100, last_grant=2.
  - Grants 7, then 2, then 7. The wrap from 7 to 2 skips invalid channels.
- **Backpressure:** out_valid=1, out_data=X, out_ready=0 for 3 cycles with other channels valid.
  - out_data and out_ch stable at X for all 3 cycles; in_ready=0 throughout.
  - On out_ready=1, the next word transfers in the same cycle with no bubble.
- **Mode switch:** mode=0 with sel=3 for 2 transfers, then mode=1 with in_valid=8'hFF.
  - First round-robin grant is ch4, since last_grant=3.
